// File: rtl/nios2_oci_action_pkg.sv
// Shared action codes, FSM states, queue entry layout and resource-bus address
// map for the OCI action sequencer.
package nios2_oci_action_pkg;

  localparam int JDO_W   = 38;
  localparam int CODE_W  = 3;
  localparam int ENTRY_W = CODE_W + JDO_W;

  localparam logic [8:0] BRK_BASE      = 9'h180;
  localparam logic [8:0] TRC_CTRL_ADDR = 9'h1C0;
  localparam logic [8:0] TRC_MEM_BASE  = 9'h100;

  // Code value doubles as strobe priority: lower code wins a collision.
  typedef enum logic [CODE_W-1:0] {
    ACT_OCIMEM_A   = 3'd0,
    ACT_OCIMEM_B   = 3'd1,
    ACT_BREAK_A    = 3'd2,
    ACT_BREAK_B    = 3'd3,
    ACT_BREAK_C    = 3'd4,
    ACT_TRACECTRL  = 3'd5,
    ACT_TRACEMEM_A = 3'd6,
    ACT_TRACEMEM_B = 3'd7
  } action_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_ABORT
  } state_t;

  typedef struct packed {
    action_code_t     code;
    logic [JDO_W-1:0] jdo;
  } entry_t;

  function automatic logic is_ocimem(action_code_t c);
    return (c == ACT_OCIMEM_A) || (c == ACT_OCIMEM_B);
  endfunction

endpackage

// File: rtl/nios2_oci_action_sequencer_if.sv
// Single-port OCI debug resource bus: held command with waitrequest stall.
interface nios2_oci_action_sequencer_if #(
  parameter int ADDR_W = 9
) ();
  logic              res_read;
  logic              res_write;
  logic [ADDR_W-1:0] res_address;
  logic [31:0]       res_writedata;
  logic              res_waitrequest;
  logic [31:0]       res_readdata;

  modport master (
    output res_read, res_write, res_address, res_writedata,
    input  res_waitrequest, res_readdata
  );

  modport slave (
    input  res_read, res_write, res_address, res_writedata,
    output res_waitrequest, res_readdata
  );
endinterface

// File: rtl/nios2_oci_action_fifo.sv
// Small synchronous first-word-fall-through FIFO; a push while full is taken
// when a pop happens in the same cycle.
module nios2_oci_action_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nios2_oci_action_sequencer.sv
// Queues JTAG take_action strobes and replays them one at a time as OCI
// resource-bus transfers, with timeout and sticky status reporting.
module nios2_oci_action_sequencer
  import nios2_oci_action_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int ADDR_W     = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_action_break_a,
  input  logic        take_action_break_b,
  input  logic        take_action_break_c,
  input  logic        take_action_tracectrl,
  input  logic        take_action_tracemem_a,
  input  logic        take_action_tracemem_b,
  input  logic [37:0] jdo,
  input  logic        clr_status,
  nios2_oci_action_sequencer_if.master bus,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  output logic        busy,
  output logic        overflow,
  output logic        collision
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [7:0]        w_strobes;
  logic              w_any;
  logic              w_multi;
  action_code_t      w_code;
  entry_t            w_push_entry;
  entry_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic              w_abort;
  logic              w_ovf_set;
  state_t            w_state_next;
  logic              w_dec_read;
  logic              w_dec_write;
  logic [ADDR_W-1:0] w_dec_addr;
  logic [31:0]       w_dec_data;
  logic [1:0]        w_brk_idx;
  logic [2:0]        w_head_code;
  logic              w_unused_jdo;

  state_t            r_state;
  action_code_t      r_code;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_ptr;
  logic [6:0]        r_tptr;
  logic [31:0]       r_mondreg;
  logic              r_ready;
  logic              r_error;
  logic              r_overflow;
  logic              r_collision;

  assign w_strobes = {take_action_tracemem_b, take_action_tracemem_a,
                      take_action_tracectrl, take_action_break_c,
                      take_action_break_b, take_action_break_a,
                      take_action_ocimem_b, take_action_ocimem_a};

  always_comb begin
    w_any   = |w_strobes;
    w_multi = (w_strobes & (w_strobes - 8'd1)) != 8'd0;
    w_code  = ACT_OCIMEM_A;
    for (int i = 7; i >= 0; i--) begin
      if (w_strobes[i]) w_code = action_code_t'(3'(i));
    end
  end

  assign w_push_entry = '{code: w_code, jdo: jdo};
  assign w_push       = w_any && (!w_full || w_pop);
  assign w_ovf_set    = w_any && w_full && !w_pop;

  nios2_oci_action_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_push_entry),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_head_code  = w_head.code;
  assign w_brk_idx    = w_head_code[1:0] - 2'd2;
  assign w_unused_jdo = ^w_head.jdo[37:36];

  // Decode is taken from the queue head; ocimem_b/tracemem_b use the
  // pointers as they stand when the entry is popped.
  always_comb begin
    w_dec_read  = 1'b0;
    w_dec_write = 1'b0;
    w_dec_addr  = '0;
    w_dec_data  = '0;
    case (w_head.code)
      ACT_OCIMEM_A: begin
        w_dec_read = 1'b1;
        w_dec_addr = ADDR_W'(w_head.jdo[8:0]);
      end
      ACT_OCIMEM_B: begin
        w_dec_write = 1'b1;
        w_dec_addr  = r_ptr;
        w_dec_data  = w_head.jdo[34:3];
      end
      ACT_BREAK_A, ACT_BREAK_B, ACT_BREAK_C: begin
        w_dec_write = 1'b1;
        w_dec_addr  = ADDR_W'(BRK_BASE) + ADDR_W'({w_brk_idx, w_head.jdo[35:34]});
        w_dec_data  = w_head.jdo[31:0];
      end
      ACT_TRACECTRL: begin
        w_dec_write = 1'b1;
        w_dec_addr  = ADDR_W'(TRC_CTRL_ADDR);
        w_dec_data  = {16'b0, w_head.jdo[15:0]};
      end
      ACT_TRACEMEM_A: begin
        w_dec_read = 1'b1;
        w_dec_addr = ADDR_W'(TRC_MEM_BASE) + ADDR_W'(w_head.jdo[6:0]);
      end
      ACT_TRACEMEM_B: begin
        w_dec_read = 1'b1;
        w_dec_addr = ADDR_W'(TRC_MEM_BASE) + ADDR_W'(r_tptr);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_accept     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (!bus.res_waitrequest) begin
          w_accept     = 1'b1;
          w_state_next = ST_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_abort      = 1'b1;
          w_state_next = ST_ABORT;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      ST_ABORT: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_code      <= ACT_OCIMEM_A;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_tptr      <= '0;
      r_mondreg   <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
      r_overflow  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_code  <= w_head.code;
        r_read  <= w_dec_read;
        r_write <= w_dec_write;
        r_addr  <= w_dec_addr;
        r_wdata <= w_dec_data;
        r_ready <= 1'b0;
      end
      if (r_state == ST_ISSUE) r_cnt <= '0;
      else if (r_state == ST_WAIT && !w_accept && !w_abort) r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept || w_abort) begin
        r_read  <= 1'b0;
        r_write <= 1'b0;
      end
      if (w_accept && r_read) r_mondreg <= bus.res_readdata;
      if (r_state == ST_DONE) begin
        r_ready <= 1'b1;
        if (is_ocimem(r_code))          r_ptr  <= r_addr + ADDR_W'(1);
        if (r_code == ACT_TRACEMEM_B)   r_tptr <= r_tptr + 7'd1;
      end
      if (r_state == ST_ABORT) r_ready <= 1'b0;
      // Set events take precedence over a coincident clear.
      if (r_state == ST_ABORT) r_error     <= 1'b1;
      else if (clr_status)     r_error     <= 1'b0;
      if (w_ovf_set)           r_overflow  <= 1'b1;
      else if (clr_status)     r_overflow  <= 1'b0;
      if (w_any && w_multi)    r_collision <= 1'b1;
      else if (clr_status)     r_collision <= 1'b0;
    end
  end

  assign bus.res_read      = r_read;
  assign bus.res_write     = r_write;
  assign bus.res_address   = r_addr;
  assign bus.res_writedata = r_wdata;
  assign MonDReg           = r_mondreg;
  assign monitor_ready     = r_ready;
  assign monitor_error     = r_error;
  assign overflow          = r_overflow;
  assign collision         = r_collision;
  assign busy              = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_nios2_oci_action_sequencer.sv
// Directed bench: a stall-programmable bus model logs every transfer, and
// each step checks outputs and the log against hand-derived values.
module tb_nios2_oci_action_sequencer;
  import nios2_oci_action_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  strb;
  logic [37:0] jdo;
  logic        clr_status;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, busy, overflow, collision;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        stuck    = 1'b0;
  int          stall_len = 0;
  int          stall_cnt = 0;
  logic [31:0] rd_value = '0;
  logic        prev_cmd = 1'b0;
  int          n_xfer   = 0;
  logic        log_wr   [32];
  logic [8:0]  log_addr [32];
  logic [31:0] log_data [32];
  int          base;
  int          hi;

  always #5 clk = ~clk;

  nios2_oci_action_sequencer_if #(.ADDR_W(9)) bus ();

  nios2_oci_action_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(255), .ADDR_W(9)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .take_action_ocimem_a   (strb[0]),
    .take_action_ocimem_b   (strb[1]),
    .take_action_break_a    (strb[2]),
    .take_action_break_b    (strb[3]),
    .take_action_break_c    (strb[4]),
    .take_action_tracectrl  (strb[5]),
    .take_action_tracemem_a (strb[6]),
    .take_action_tracemem_b (strb[7]),
    .jdo                    (jdo),
    .clr_status             (clr_status),
    .bus                    (bus),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .busy                   (busy),
    .overflow               (overflow),
    .collision              (collision)
  );

  wire cmd = bus.res_read | bus.res_write;
  assign bus.res_waitrequest = stuck || (stall_cnt < stall_len);
  assign bus.res_readdata    = rd_value;

  // Bus model: stall counter and one log record per command rising edge.
  always @(posedge clk) begin
    stall_cnt <= cmd ? stall_cnt + 1 : 0;
    prev_cmd  <= cmd;
    if (cmd && !prev_cmd && n_xfer < 32) begin
      log_wr[n_xfer]   <= bus.res_write;
      log_addr[n_xfer] <= bus.res_address;
      log_data[n_xfer] <= bus.res_writedata;
      n_xfer           <= n_xfer + 1;
    end
    n_checks++;
    assert (!(bus.res_read && bus.res_write)) else begin
      n_fail++;
      $error("FAIL rd_wr_exclusive observed=11 expected=not both");
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] s, input logic [37:0] d);
    strb = s;
    jdo  = d;
    tick();
    strb = '0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 1000) begin
      tick();
      k++;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    strb = '0; jdo = '0; clr_status = 1'b0; reset = 1'b1;
    repeat (3) tick();
    check("rst_read", bus.res_read, 0);
    check("rst_write", bus.res_write, 0);
    check("rst_addr", bus.res_address, 0);
    check("rst_wdata", bus.res_writedata, 0);
    check("rst_mondreg", MonDReg, 0);
    check("rst_ready", monitor_ready, 0);
    check("rst_error", monitor_error, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_collision", collision, 0);
    reset = 1'b0;
    tick();

    // ocimem_a read at 0x010, zero-wait bus, cycle-exact timing.
    rd_value = 32'hDEADBEEF;
    base = n_xfer;
    strobe(8'h01, 38'h010);
    check("t1_cmd_c1", cmd, 0);
    check("t1_busy_c1", busy, 1);
    tick();
    check("t1_read_c2", bus.res_read, 1);
    check("t1_addr_c2", bus.res_address, 9'h010);
    check("t1_write_c2", bus.res_write, 0);
    tick();
    check("t1_read_c3", bus.res_read, 1);
    tick();
    check("t1_read_c4", bus.res_read, 0);
    check("t1_mondreg", MonDReg, 32'hDEADBEEF);
    tick();
    check("t1_ready", monitor_ready, 1);
    check("t1_busy_end", busy, 0);
    check("t1_nxfer", n_xfer - base, 1);

    // ocimem_a 0x1FF then two ocimem_b writes wrap the pointer to 0, 1.
    base = n_xfer;
    strobe(8'h01, 38'h1FF);
    strobe(8'h02, 38'(32'h11) << 3);
    strobe(8'h02, 38'(32'h22) << 3);
    wait_idle("t2_idle");
    check("t2_nxfer", n_xfer - base, 3);
    check("t2_x0_wr", log_wr[base], 0);
    check("t2_x0_addr", log_addr[base], 9'h1FF);
    check("t2_x1_wr", log_wr[base+1], 1);
    check("t2_x1_addr", log_addr[base+1], 9'h000);
    check("t2_x1_data", log_data[base+1], 32'h11);
    check("t2_x2_addr", log_addr[base+2], 9'h001);
    check("t2_x2_data", log_data[base+2], 32'h22);

    // tracemem_b reads walk the trace pointer from TRC_MEM_BASE.
    rd_value = 32'h12345678;
    base = n_xfer;
    strobe(8'h80, 38'h0);
    strobe(8'h80, 38'h0);
    wait_idle("t6_idle");
    check("t6_x0_addr", log_addr[base], 9'h100);
    check("t6_x1_addr", log_addr[base+1], 9'h101);
    check("t6_mondreg", MonDReg, 32'h12345678);

    // break_b + tracectrl together: break wins at BRK_BASE + {01,10}.
    base = n_xfer;
    strobe(8'h28, 38'h8_CAFE_F00D);
    wait_idle("t5_idle");
    check("t5_nxfer", n_xfer - base, 1);
    check("t5_wr", log_wr[base], 1);
    check("t5_addr", log_addr[base], 9'h186);
    check("t5_data", log_data[base], 32'hCAFEF00D);
    check("t5_collision", collision, 1);
    check("t5_overflow", overflow, 0);
    pulse_clr();
    check("t5_clr_collision", collision, 0);
    // A collision in the clr_status cycle keeps the flag set.
    base = n_xfer;
    strb = 8'hC0; jdo = 38'h05; clr_status = 1'b1;
    tick();
    strb = '0; clr_status = 1'b0;
    check("t5_setwins", collision, 1);
    wait_idle("t5b_idle");
    check("t5b_addr", log_addr[base], 9'h105);
    check("t5b_wr", log_wr[base], 0);

    // Six back-to-back strobes with a 10-cycle stall: the first is popped
    // at once, four fill the queue, the sixth is dropped.
    stall_len = 10;
    base = n_xfer;
    for (int i = 0; i < 6; i++) begin
      strb = 8'h20;
      jdo  = 38'(i + 1);
      tick();
    end
    strb = '0;
    check("t3_overflow", overflow, 1);
    wait_idle("t3_idle");
    check("t3_nxfer", n_xfer - base, 5);
    check("t3_first_data", log_data[base], 32'd1);
    check("t3_last_data", log_data[base+4], 32'd5);
    stall_len = 0;

    // Stuck waitrequest: ISSUE + 256 WAIT cycles then abort; next op runs.
    pulse_clr();
    check("t4_clr_overflow", overflow, 0);
    check("t4_clr_collision", collision, 0);
    stuck = 1'b1;
    base = n_xfer;
    strobe(8'h40, 38'h05);
    strobe(8'h20, 38'hABCD);
    hi = 0;
    for (int k = 0; k < 400; k++) begin
      if (cmd) hi++;
      else if (hi > 0) break;
      tick();
    end
    check("t4_cmd_cycles", hi, 257);
    stuck = 1'b0;
    tick();
    check("t4_error", monitor_error, 1);
    wait_idle("t4_idle");
    check("t4_nxfer", n_xfer - base, 2);
    check("t4_next_wr", log_wr[base+1], 1);
    check("t4_next_addr", log_addr[base+1], 9'h1C0);
    check("t4_next_data", log_data[base+1], 32'h0000ABCD);
    check("t4_ready", monitor_ready, 1);
    check("t4_error_hold", monitor_error, 1);

    // Reset during WAIT flushes everything; no retry afterwards.
    stuck = 1'b1;
    strobe(8'h01, 38'h33);
    strobe(8'h20, 38'h44);
    repeat (3) tick();
    check("t7_cmd_pre", bus.res_read, 1);
    reset = 1'b1;
    tick();
    check("t7_read", bus.res_read, 0);
    check("t7_write", bus.res_write, 0);
    check("t7_busy", busy, 0);
    check("t7_mondreg", MonDReg, 0);
    check("t7_ready", monitor_ready, 0);
    check("t7_error", monitor_error, 0);
    check("t7_addr", bus.res_address, 0);
    reset = 1'b0;
    stuck = 1'b0;
    base = n_xfer;
    repeat (10) tick();
    check("t7_no_retry", n_xfer - base, 0);
    check("t7_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
